// File: rtl/iterative_mul_unit_if.sv
// Handshake and data bundle between the execute-stage controller and the
// iterative multiply unit. The controller drives the master side.
interface iterative_mul_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             flush;
  logic             op_long;
  logic             op_signed;
  logic             op_acc;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] acc_hi;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic             flag_n;
  logic             flag_z;

  modport master (
    output start, flush, op_long, op_signed, op_acc,
    output operand_a, operand_b, acc_lo, acc_hi,
    input  busy, done, result_lo, result_hi, flag_n, flag_z
  );

  modport slave (
    input  start, flush, op_long, op_signed, op_acc,
    input  operand_a, operand_b, acc_lo, acc_hi,
    output busy, done, result_lo, result_hi, flag_n, flag_z
  );
endinterface

// File: rtl/iterative_mul_unit.sv
// Radix-2 shift-add multiply / multiply-accumulate unit (MUL, MLA, UMULL/UMLAL,
// SMULL/SMLAL). One multiplier bit per cycle, followed by a single fix-up cycle.
module iterative_mul_unit #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  iterative_mul_unit_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int PW    = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Operation context captured at acceptance
  logic [PW-1:0]    mcand_q;
  logic [PW-1:0]    prod_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_lo_q;
  logic [WIDTH-1:0] acc_hi_q;
  logic [CNT_W-1:0] cnt_q;
  logic             long_q;
  logic             acc_q;
  logic             neg_q;

  // Architecturally visible results
  logic [WIDTH-1:0] res_lo_q;
  logic [WIDTH-1:0] res_hi_q;
  logic             flag_n_q;
  logic             flag_z_q;

  logic             accept;
  logic             last_iter;
  logic             signed_long;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [PW-1:0]    prod_fixed;
  logic [PW-1:0]    addend;
  logic [PW-1:0]    fix_sum;

  assign accept    = bus.start && !bus.flush && (state == IDLE || state == DONE);
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every always_comb output gets a default before the case so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = BUSY;
      BUSY:    if (last_iter) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = accept ? BUSY : IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.flush) state_nxt = IDLE;
  end

  // Signed long forms run the unsigned engine on magnitudes; the most negative
  // value maps to 2^(WIDTH-1), which still fits in WIDTH unsigned bits.
  assign signed_long = bus.op_signed && bus.op_long;
  assign a_neg       = signed_long && bus.operand_a[WIDTH-1];
  assign b_neg       = signed_long && bus.operand_b[WIDTH-1];
  assign a_mag       = a_neg ? -bus.operand_a : bus.operand_a;
  assign b_mag       = b_neg ? -bus.operand_b : bus.operand_b;

  // Fix-up: restore the sign, then fold in the accumulator, all mod 2^(2*WIDTH)
  assign prod_fixed = neg_q ? -prod_q : prod_q;
  assign addend     = !acc_q  ? '0 :
                      long_q  ? {acc_hi_q, acc_lo_q} :
                                {{WIDTH{1'b0}}, acc_lo_q};
  assign fix_sum    = prod_fixed + addend;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcand_q  <= '0;
      prod_q   <= '0;
      mplier_q <= '0;
      acc_lo_q <= '0;
      acc_hi_q <= '0;
      cnt_q    <= '0;
      long_q   <= 1'b0;
      acc_q    <= 1'b0;
      neg_q    <= 1'b0;
    end else if (accept) begin
      mcand_q  <= {{WIDTH{1'b0}}, a_mag};
      mplier_q <= b_mag;
      prod_q   <= '0;
      cnt_q    <= '0;
      acc_lo_q <= bus.acc_lo;
      acc_hi_q <= bus.acc_hi;
      long_q   <= bus.op_long;
      acc_q    <= bus.op_acc;
      neg_q    <= a_neg ^ b_neg;
    end else if (state == BUSY && !bus.flush) begin
      if (mplier_q[0]) prod_q <= prod_q + mcand_q;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CNT_W'(1);
    end
  end

  // Results and flags change only on a FIX cycle that is not being flushed
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_lo_q <= '0;
      res_hi_q <= '0;
      flag_n_q <= 1'b0;
      flag_z_q <= 1'b0;
    end else if (state == FIX && !bus.flush) begin
      res_lo_q <= fix_sum[WIDTH-1:0];
      res_hi_q <= long_q ? fix_sum[PW-1:WIDTH] : '0;
      flag_n_q <= long_q ? fix_sum[PW-1] : fix_sum[WIDTH-1];
      flag_z_q <= long_q ? (fix_sum == '0) : (fix_sum[WIDTH-1:0] == '0);
    end
  end

  assign bus.busy      = (state == BUSY) || (state == FIX);
  assign bus.done      = (state == DONE);
  assign bus.result_lo = res_lo_q;
  assign bus.result_hi = res_hi_q;
  assign bus.flag_n    = flag_n_q;
  assign bus.flag_z    = flag_z_q;
endmodule

// File: tb/tb_iterative_mul_unit.sv
// Scoreboard bench for iterative_mul_unit: a WIDTH=32 instance for the directed
// cases and a WIDTH=8 instance for the randomised reference-model regression.
module tb_iterative_mul_unit;
  typedef struct {
    logic [63:0] lo;
    logic [63:0] hi;
    logic        n;
    logic        z;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  exp_t q32[$];
  exp_t q8[$];
  exp_t last32;
  int   done_cyc32[$];

  iterative_mul_unit_if #(.WIDTH(32)) b32 ();
  iterative_mul_unit_if #(.WIDTH(8))  b8 ();

  iterative_mul_unit #(.WIDTH(32)) u32 (.clk(clk), .reset(reset), .bus(b32));
  iterative_mul_unit #(.WIDTH(8))  u8  (.clk(clk), .reset(reset), .bus(b8));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic exp_t mk(logic [63:0] lo, logic [63:0] hi, logic n, logic z);
    exp_t e;
    e.lo = lo; e.hi = hi; e.n = n; e.z = z;
    return e;
  endfunction

  // Reference: exact product of the (sign-extended) operands in wide arithmetic
  function automatic exp_t model(int w, bit lng, bit sgn, bit acc,
                                 logic [63:0] a, logic [63:0] b,
                                 logic [63:0] alo, logic [63:0] ahi);
    logic signed [127:0] sa, sb, p;
    logic [127:0] accv, r, wmask, m2;
    exp_t e;
    wmask = (128'd1 << w) - 128'd1;
    m2    = (128'd1 << (2 * w)) - 128'd1;
    sa = $signed({64'd0, a});
    sb = $signed({64'd0, b});
    if (lng && sgn) begin
      if (a[w-1]) sa = sa - (128'sd1 <<< w);
      if (b[w-1]) sb = sb - (128'sd1 <<< w);
    end
    p = sa * sb;
    accv = '0;
    if (acc) accv = lng ? (({64'd0, ahi} << w) | {64'd0, alo}) : {64'd0, alo};
    r = (128'(p) + accv) & m2;
    e.lo = 64'(r & wmask);
    e.hi = lng ? 64'((r >> w) & wmask) : 64'd0;
    e.n  = lng ? r[2*w-1] : r[w-1];
    e.z  = lng ? (r == '0) : ((r & wmask) == '0);
    return e;
  endfunction

  always @(negedge clk) begin : mon32
    exp_t e;
    if (reset === 1'b1 && b32.done === 1'b1) begin
      total++;
      if (q32.size() == 0) begin
        bad++;
        $display("FAIL done32_unexpected cyc=%0d lo=%h hi=%h", cyc, b32.result_lo, b32.result_hi);
      end else begin
        e = q32.pop_front();
        done_cyc32.push_back(cyc);
        if (b32.result_lo !== e.lo[31:0] || b32.result_hi !== e.hi[31:0] ||
            b32.flag_n !== e.n || b32.flag_z !== e.z) begin
          bad++;
          $display("FAIL result32 got lo=%h hi=%h n=%b z=%b expected lo=%h hi=%h n=%b z=%b",
                   b32.result_lo, b32.result_hi, b32.flag_n, b32.flag_z,
                   e.lo[31:0], e.hi[31:0], e.n, e.z);
        end
        last32 = e;
      end
    end
  end

  always @(negedge clk) begin : mon8
    exp_t e;
    if (reset === 1'b1 && b8.done === 1'b1) begin
      total++;
      if (q8.size() == 0) begin
        bad++;
        $display("FAIL done8_unexpected cyc=%0d", cyc);
      end else begin
        e = q8.pop_front();
        if (b8.result_lo !== e.lo[7:0] || b8.result_hi !== e.hi[7:0] ||
            b8.flag_n !== e.n || b8.flag_z !== e.z) begin
          bad++;
          $display("FAIL result8 got lo=%h hi=%h n=%b z=%b expected lo=%h hi=%h n=%b z=%b",
                   b8.result_lo, b8.result_hi, b8.flag_n, b8.flag_z,
                   e.lo[7:0], e.hi[7:0], e.n, e.z);
        end
      end
    end
  end

  // Drives one request through edge E0; returns at the falling edge after E0
  task automatic launch32(input logic lng, input logic sgn, input logic acc,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] alo, input logic [31:0] ahi, input exp_t e);
    @(negedge clk);
    b32.op_long = lng; b32.op_signed = sgn; b32.op_acc = acc;
    b32.operand_a = a; b32.operand_b = b; b32.acc_lo = alo; b32.acc_hi = ahi;
    b32.start = 1'b1;
    q32.push_back(e);
    @(posedge clk);
    @(negedge clk);
    b32.start = 1'b0;
  endtask

  task automatic launch8(input logic lng, input logic sgn, input logic acc,
                         input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] alo, input logic [7:0] ahi);
    @(negedge clk);
    b8.op_long = lng; b8.op_signed = sgn; b8.op_acc = acc;
    b8.operand_a = a; b8.operand_b = b; b8.acc_lo = alo; b8.acc_hi = ahi;
    b8.start = 1'b1;
    q8.push_back(model(8, lng, sgn, acc, 64'(a), 64'(b), 64'(alo), 64'(ahi)));
    @(posedge clk);
    @(negedge clk);
    b8.start = 1'b0;
  endtask

  // Rising edges counted until done is seen; -1 when the budget runs out
  task automatic wait_done32(output int n);
    n = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (b32.done === 1'b1) begin n = i; break; end
    end
  endtask

  task automatic wait_done8(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (b8.done === 1'b1) begin n = i; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({b32.busy, b32.done, b32.result_lo, b32.result_hi, b32.flag_n, b32.flag_z} !== '0) begin
      bad++;
      $display("FAIL reset32 busy=%b done=%b lo=%h hi=%h n=%b z=%b required all 0",
               b32.busy, b32.done, b32.result_lo, b32.result_hi, b32.flag_n, b32.flag_z);
    end
    total++;
    if ({b8.busy, b8.done, b8.result_lo, b8.result_hi, b8.flag_n, b8.flag_z} !== '0) begin
      bad++;
      $display("FAIL reset8 busy=%b done=%b lo=%h hi=%h required all 0",
               b8.busy, b8.done, b8.result_lo, b8.result_hi);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    total++;
    if (b32.busy !== 1'b0 || b32.done !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset busy=%b done=%b required 0 0", b32.busy, b32.done);
    end
  endtask

  task automatic test_mul();
    int n;
    int busy_cycles;
    launch32(1'b0, 1'b0, 1'b0, 32'd7, 32'd6, 32'd0, 32'd0, mk(64'd42, 64'd0, 1'b0, 1'b0));
    busy_cycles = (b32.busy === 1'b1) ? 1 : 0;
    n = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (b32.done === 1'b1) begin n = i + 1; break; end
      if (b32.busy === 1'b1) busy_cycles++;
    end
    // n counts edges from E0 inclusive, so done after E33 gives n-1 = 33
    total++;
    if (n - 1 != 33) begin
      bad++;
      $display("FAIL mul_latency edges=%0d required 33", n - 1);
    end
    total++;
    if (busy_cycles != 33) begin
      bad++;
      $display("FAIL mul_busy_cycles got=%0d required 33", busy_cycles);
    end
    @(posedge clk); #1;
    total++;
    if (b32.done !== 1'b0) begin
      bad++;
      $display("FAIL done_pulse_width done=%b one cycle after pulse, required 0", b32.done);
    end
  endtask

  task automatic test_mla_wrap();
    int n;
    launch32(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd2, 32'd3, 32'hDEAD_BEEF,
             mk(64'd1, 64'd0, 1'b0, 1'b0));
    wait_done32(n);
    total++;
    if (n != 33) begin bad++; $display("FAIL mla_latency got=%0d required 33", n); end
  endtask

  task automatic test_long_forms();
    int n;
    logic [31:0] av[5];
    logic [31:0] bv[5];
    logic [31:0] alov[5];
    logic        lv[5];
    logic        sv[5];
    logic        cv[5];
    exp_t        ev[5];
    av[0] = 32'hFFFF_FFFF; bv[0] = 32'hFFFF_FFFF; alov[0] = 0; lv[0] = 1; sv[0] = 0; cv[0] = 0;
    ev[0] = mk(64'h0000_0001, 64'hFFFF_FFFE, 1'b1, 1'b0);
    av[1] = 32'h8000_0000; bv[1] = 32'h8000_0000; alov[1] = 0; lv[1] = 1; sv[1] = 1; cv[1] = 0;
    ev[1] = mk(64'h0, 64'h4000_0000, 1'b0, 1'b0);
    av[2] = 32'hFFFF_FFFF; bv[2] = 32'd5; alov[2] = 0; lv[2] = 1; sv[2] = 1; cv[2] = 0;
    ev[2] = mk(64'hFFFF_FFFB, 64'hFFFF_FFFF, 1'b1, 1'b0);
    av[3] = 32'hFFFF_FFFE; bv[3] = 32'd3; alov[3] = 32'd6; lv[3] = 1; sv[3] = 1; cv[3] = 1;
    ev[3] = mk(64'h0, 64'h0, 1'b0, 1'b1);
    // op_signed without op_long: plain MUL, high half stays 0
    av[4] = 32'hFFFF_FFFF; bv[4] = 32'hFFFF_FFFF; alov[4] = 0; lv[4] = 0; sv[4] = 1; cv[4] = 0;
    ev[4] = mk(64'h1, 64'h0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      launch32(lv[k], sv[k], cv[k], av[k], bv[k], alov[k], 32'd0, ev[k]);
      wait_done32(n);
      total++;
      if (n != 33) begin bad++; $display("FAIL long_latency case=%0d got=%0d required 33", k, n); end
    end
  endtask

  task automatic test_start_ignored();
    int n;
    launch32(1'b0, 1'b0, 1'b0, 32'd1000, 32'd3000, 32'd0, 32'd0,
             mk(64'd3000000, 64'd0, 1'b0, 1'b0));
    repeat (4) @(posedge clk);
    @(negedge clk);
    b32.operand_a = 32'd5; b32.operand_b = 32'd5; b32.start = 1'b1;
    @(negedge clk);
    b32.start = 1'b0;
    wait_done32(n);
    total++;
    if (n != 28) begin bad++; $display("FAIL start_ignored_latency got=%0d required 28", n); end
    repeat (40) @(negedge clk);
    total++;
    if (q32.size() != 0) begin
      bad++;
      $display("FAIL start_ignored_pending got=%0d required 0", q32.size());
    end
  endtask

  task automatic test_flush();
    launch32(1'b0, 1'b0, 1'b0, 32'd123, 32'd456, 32'd0, 32'd0, mk(64'd56088, 64'd0, 1'b0, 1'b0));
    repeat (9) @(posedge clk);
    @(negedge clk);
    b32.flush = 1'b1;
    q32.delete(q32.size() - 1);
    @(posedge clk); #1;
    total++;
    if (b32.busy !== 1'b0 || b32.done !== 1'b0) begin
      bad++;
      $display("FAIL flush_idle busy=%b done=%b required 0 0", b32.busy, b32.done);
    end
    total++;
    if (b32.result_lo !== last32.lo[31:0] || b32.result_hi !== last32.hi[31:0]) begin
      bad++;
      $display("FAIL flush_hold got lo=%h hi=%h required lo=%h hi=%h",
               b32.result_lo, b32.result_hi, last32.lo[31:0], last32.hi[31:0]);
    end
    @(negedge clk);
    b32.flush = 1'b0;
    repeat (40) @(negedge clk);
    total++;
    if (b32.result_lo !== last32.lo[31:0] || b32.flag_n !== last32.n || b32.flag_z !== last32.z) begin
      bad++;
      $display("FAIL flush_hold_later got lo=%h n=%b z=%b required lo=%h n=%b z=%b",
               b32.result_lo, b32.flag_n, b32.flag_z, last32.lo[31:0], last32.n, last32.z);
    end
  endtask

  task automatic test_reset_mid();
    launch32(1'b1, 1'b0, 1'b0, 32'h1234_5678, 32'h0000_0100, 32'd0, 32'd0,
             mk(64'h3456_7800, 64'h12, 1'b0, 1'b0));
    repeat (7) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++;
    if ({b32.busy, b32.done, b32.result_lo, b32.result_hi, b32.flag_n, b32.flag_z} !== '0) begin
      bad++;
      $display("FAIL reset_mid busy=%b done=%b lo=%h hi=%h n=%b z=%b required all 0",
               b32.busy, b32.done, b32.result_lo, b32.result_hi, b32.flag_n, b32.flag_z);
    end
    q32.delete();
    last32 = mk(64'd0, 64'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bit   seen;
    exp_t e1;
    exp_t e2;
    e1 = model(32, 1'b1, 1'b0, 1'b0, 64'h1234_5678, 64'h9ABC_DEF0, 64'd0, 64'd0);
    e2 = model(32, 1'b1, 1'b1, 1'b1, 64'hFFFF_FFF9, 64'd100000, 64'hFFFF_FFF0, 64'hFFFF_FFFF);
    done_cyc32.delete();
    @(negedge clk);
    b32.op_long = 1'b1; b32.op_signed = 1'b0; b32.op_acc = 1'b0;
    b32.operand_a = 32'h1234_5678; b32.operand_b = 32'h9ABC_DEF0;
    b32.acc_lo = 32'd0; b32.acc_hi = 32'd0;
    b32.start = 1'b1;
    q32.push_back(e1);
    @(posedge clk);
    @(negedge clk);
    // start stays high; the second operation's operands wait on the bus
    b32.op_signed = 1'b1; b32.op_acc = 1'b1;
    b32.operand_a = 32'hFFFF_FFF9; b32.operand_b = 32'd100000;
    b32.acc_lo = 32'hFFFF_FFF0; b32.acc_hi = 32'hFFFF_FFFF;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (b32.done === 1'b1) begin seen = 1'b1; break; end
    end
    q32.push_back(e2);
    @(negedge clk);
    b32.start = 1'b0;
    for (int i = 0; i < 100 && seen; i++) begin
      @(negedge clk);
      if (b32.done === 1'b1) break;
    end
    repeat (3) @(negedge clk);
    total++;
    if (done_cyc32.size() != 2) begin
      bad++;
      $display("FAIL b2b_done_count got=%0d required 2", done_cyc32.size());
    end else begin
      total++;
      if (done_cyc32[1] - done_cyc32[0] != 34) begin
        bad++;
        $display("FAIL b2b_spacing got=%0d required 34", done_cyc32[1] - done_cyc32[0]);
      end
    end
  endtask

  task automatic test_regress8();
    int n;
    logic [7:0] a, b, alo, ahi;
    logic lng, sgn, acc;
    for (int k = 0; k < 40; k++) begin
      a = 8'($urandom); b = 8'($urandom); alo = 8'($urandom); ahi = 8'($urandom);
      lng = 1'($urandom); sgn = 1'($urandom); acc = 1'($urandom);
      if (k == 0) begin a = 8'h80; b = 8'h80; lng = 1; sgn = 1; acc = 0; end
      if (k == 1) begin a = 8'hFF; b = 8'hFF; alo = 8'hFF; ahi = 8'hFF; lng = 1; sgn = 0; acc = 1; end
      if (k == 2) begin a = 8'h80; b = 8'h7F; lng = 1; sgn = 1; acc = 0; end
      if (k == 3) begin a = 8'hFF; b = 8'h02; alo = 8'h03; lng = 0; sgn = 0; acc = 1; end
      launch8(lng, sgn, acc, a, b, alo, ahi);
      wait_done8(n);
      total++;
      if (n != 9) begin bad++; $display("FAIL latency8 case=%0d got=%0d required 9", k, n); end
    end
    @(negedge clk);
  endtask

  initial begin
    b32.start = 0; b32.flush = 0; b32.op_long = 0; b32.op_signed = 0; b32.op_acc = 0;
    b32.operand_a = '0; b32.operand_b = '0; b32.acc_lo = '0; b32.acc_hi = '0;
    b8.start = 0; b8.flush = 0; b8.op_long = 0; b8.op_signed = 0; b8.op_acc = 0;
    b8.operand_a = '0; b8.operand_b = '0; b8.acc_lo = '0; b8.acc_hi = '0;
    last32 = mk(64'd0, 64'd0, 1'b0, 1'b0);
    test_reset();
    test_mul();
    test_mla_wrap();
    test_long_forms();
    test_start_ignored();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    test_regress8();
    repeat (5) @(negedge clk);
    total++;
    if (q32.size() != 0 || q8.size() != 0) begin
      bad++;
      $display("FAIL pending_results q32=%0d q8=%0d required 0 0", q32.size(), q8.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d required completion", cyc);
    $fatal(1, "watchdog expired");
  end
endmodule
